// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and the
// state-to-occupancy mapping used by the top level.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            ST_EMPTY: occ_of = 2'd0;
            ST_ONE:   occ_of = 2'd1;
            ST_FULL:  occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dff_en_sync.sv
// WIDTH-bit register with synchronous reset, synchronous clear and load enable.
// Priority: reset, then clear, then enable.
module dff_en_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer: out_data comes straight from the main register and
// in_ready depends only on registered state, never on out_ready.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Handshake: a beat moves on a port only in a cycle where valid and ready
    // are both high at the rising edge; valid never waits on ready.
    state_t           state_q, state_d;
    logic             in_fire, out_fire;
    logic             main_en, skid_en, data_clr;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign occupancy = occ_of(state_q);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        main_en  = 1'b0;
        skid_en  = 1'b0;
        main_d   = in_data;
        data_clr = flush & CLEAR_DATA;
        if (flush) begin
            // Kill wins over any same-cycle handshake; payload is either
            // cleared (data_clr) or simply left untouched.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        main_en = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    dff_en_sync #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (data_clr),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    dff_en_sync #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (data_clr),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based model compared every cycle against a
// clearing instance, plus directed literal checks on both flush flavours.
module tb_pipe_skid_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_occ;
    logic         b_in_ready, b_out_valid;
    logic [7:0]   b_out_data;
    logic [1:0]   b_occ;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] hold_data = '0;
    bit           started = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .CLEAR_DATA(1'b1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    pipe_skid_stage #(.WIDTH(8), .CLEAR_DATA(1'b0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data[7:0]),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the stage is a FIFO of capacity two; out_data shows the head,
    // or the last head seen once empty (zero after reset / clearing flush).
    always @(posedge clk) begin : model
        bit acc, emit;
        if (reset) begin
            exp_q.delete();
            hold_data = '0;
            started   = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            hold_data = '0;
        end else begin
            acc  = in_valid && (exp_q.size() < 2);
            emit = out_ready && (exp_q.size() > 0);
            if (emit) hold_data = exp_q.pop_front();
            if (acc) exp_q.push_back(in_data);
            if (exp_q.size() > 0) hold_data = exp_q[0];
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_out_valid", 32'(a_out_valid), 32'(exp_q.size() > 0));
            chk("cyc_in_ready",  32'(a_in_ready),  32'(exp_q.size() < 2));
            chk("cyc_occupancy", 32'(a_occ),       32'(exp_q.size()));
            chk("cyc_out_data",  a_out_data,       hold_data);
        end
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_occ",       32'(a_occ),       32'd0);
        chk("rst_out_data",  a_out_data,       32'd0);
        chk("rst_b_out_data", 32'(b_out_data), 32'd0);
        reset = 1'b0;

        // Single beat, one-cycle latency
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        tick();
        chk("lat_out_valid", 32'(a_out_valid), 32'd1);
        chk("lat_out_data",  a_out_data,       32'hA5);
        chk("lat_occ",       32'(a_occ),       32'd1);
        in_valid = 1'b0;
        tick();
        chk("lat_drained",   32'(a_occ),       32'd0);

        // Backpressure fills the skid; third beat held off
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("bp_occ_full",   32'(a_occ),       32'd2);
        chk("bp_in_ready",   32'(a_in_ready),  32'd0);
        chk("bp_head",       a_out_data,       32'h11);
        in_data = 32'h33;
        tick();
        chk("bp_hold_data",  a_out_data,       32'h11);
        chk("bp_hold_occ",   32'(a_occ),       32'd2);
        out_ready = 1'b1;
        tick();
        chk("bp_second",     a_out_data,       32'h22);
        chk("bp_second_occ", 32'(a_occ),       32'd1);
        tick();
        chk("bp_third",      a_out_data,       32'h33);
        in_valid = 1'b0;
        tick();
        chk("bp_empty",      32'(a_out_valid), 32'd0);

        // Full-throughput stream 1..100
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_data = 32'(i);
            tick();
            chk("stream_data", a_out_data, 32'(i));
            chk("stream_occ",  32'(a_occ), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        // Flush in FULL with a competing input; both flush flavours
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_pre_occ",    32'(a_occ),       32'd2);
        flush = 1'b1; in_data = 32'h44;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_out_valid",  32'(a_out_valid), 32'd0);
        chk("fl_occ",        32'(a_occ),       32'd0);
        chk("fl_main_zero",  a_out_data,       32'd0);
        chk("fl_skid_zero",  dut_a.skid_q,     32'd0);
        chk("fl_b_retained", 32'(b_out_data),  32'h11);
        tick();
        chk("fl_no_44",      32'(a_out_valid), 32'd0);

        // Retaining flush from ONE
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5A;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("keep_b_valid",  32'(b_out_valid), 32'd0);
        chk("keep_b_data",   32'(b_out_data),  32'h5A);
        chk("keep_a_data",   a_out_data,       32'd0);

        // Reset and flush together while FULL
        in_valid = 1'b1; in_data = 32'h66;
        tick();
        in_data = 32'h77;
        tick();
        chk("rf_pre_occ",    32'(a_occ),       32'd2);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rf_occ",        32'(a_occ),       32'd0);
        chk("rf_in_ready",   32'(a_in_ready),  32'd1);
        chk("rf_out_data",   a_out_data,       32'd0);
        chk("rf_skid",       dut_a.skid_q,     32'd0);
        chk("rf_b_data",     32'(b_out_data),  32'd0);

        // Random valid/ready soak against the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_data   = $urandom;
            tick();
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5 && a_occ != 2'd0; i++) tick();
        chk("drain_occ",     32'(a_occ),       32'd0);
        chk("drain_model",   32'(exp_q.size()), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
